mips_imem_loader: RTL and testbench

- Writer side of the instruction memory that the PC stage fetches from.
- Accepts a framed byte stream over a valid/ready handshake, packs bytes into 32-bit big-endian words and writes them sequentially from word address 0.
- Holds the pipeline while loading; releases it only after a complete, verified frame.
- Sits beside the pipeline top; its write port drives the instruction-memory write side.

---
 rtl/mips_imem_loader_pkg.sv | 24 ++
 rtl/mips_imem_loader_pack.sv | 37 +++
 rtl/mips_imem_loader.sv | 132 +++++++++++++
 tb/tb_mips_imem_loader.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_imem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
package mips_imem_loader_pkg;

    localparam logic [7:0] HEADER_BYTE = 8'hA5;

    typedef logic [31:0] word_t;

    typedef enum logic [2:0] {
        IDLE,
        COUNT,
        DATA,
        CHECK,
        DONE,
        ERROR
    } state_t;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

endpackage

// File: rtl/mips_imem_loader_pack.sv
// Byte-to-word shifter: packs four bytes MSB-first into one word.
module mips_imem_loader_pack
    import mips_imem_loader_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clear,
    input  logic       shift,
    input  logic [7:0] data,
    output word_t      word,
    output logic       word_valid,
    output logic       last
);

    logic [1:0] cnt;

    assign last = (cnt == 2'd3);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt        <= 2'd0;
            word       <= '0;
            word_valid <= 1'b0;
        end else if (clear) begin
            cnt        <= 2'd0;
            word       <= '0;
            word_valid <= 1'b0;
        end else begin
            word_valid <= shift && last;
            if (shift) begin
                word <= {word[23:0], data};
                cnt  <= cnt + 2'd1;
            end
        end
    end

endmodule

// File: rtl/mips_imem_loader.sv
// Framed byte-stream loader for the instruction memory.
// Optional trailing checksum: MIPS_IMEM_LOADER_CHECKSUM_EN.
module mips_imem_loader
    import mips_imem_loader_pkg::*;
#(
    parameter int         ADDR_L = 64,
    parameter int         ADDR_W = clog2(ADDR_L),
    parameter logic [7:0] HEADER = HEADER_BYTE
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        inData,
    input  logic              inValid,
    output logic              inReady,
    output logic              memWe,
    output logic [ADDR_W-1:0] memAddr,
    output logic [31:0]       memData,
    output logic              holdPipe,
    output logic              done,
    output logic              error
);

    state_t            state;
    state_t            state_nx;
    logic              acc;
    logic              idle_like;
    logic              start;
    logic              data_en;
    logic              last;
    logic              too_big;
    logic [ADDR_W:0]   n_words;
    logic [ADDR_W:0]   words_left;
    logic [ADDR_W-1:0] widx;
    word_t             word;
    logic              word_valid;

    assign acc       = inValid && inReady;
    assign idle_like = (state == IDLE) || (state == DONE) || (state == ERROR);
    assign start     = acc && idle_like && (inData == HEADER);
    assign data_en   = acc && (state == DATA);
    assign too_big   = int'(inData) > ADDR_L;
    assign n_words   = (inData == 8'd0) ? (ADDR_W+1)'(ADDR_L)
                                        : (ADDR_W+1)'(inData);

    mips_imem_loader_pack u_pack (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (start),
        .shift      (data_en),
        .data       (inData),
        .word       (word),
        .word_valid (word_valid),
        .last       (last)
    );

    // The write cycle is a stall so memory sees a stable word.
    assign memWe    = word_valid;
    assign inReady  = !word_valid;
    assign memAddr  = widx;
    assign memData  = word;
    assign holdPipe = (state != DONE) || memWe;
    assign done     = (state == DONE) && !memWe;
    assign error    = (state == ERROR);

`ifdef MIPS_IMEM_LOADER_CHECKSUM_EN
    logic [7:0] csum;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            csum <= 8'd0;
        end else if (start) begin
            csum <= 8'd0;
        end else if (data_en) begin
            csum <= csum + inData;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        if (acc) begin
            unique case (state)
                IDLE, DONE, ERROR: begin
                    if (inData == HEADER) state_nx = COUNT;
                end
                COUNT: state_nx = too_big ? ERROR : DATA;
                DATA: begin
                    if (last && words_left == (ADDR_W+1)'(1)) begin
`ifdef MIPS_IMEM_LOADER_CHECKSUM_EN
                        state_nx = CHECK;
`else
                        state_nx = DONE;
`endif
                    end
                end
`ifdef MIPS_IMEM_LOADER_CHECKSUM_EN
                CHECK: state_nx = (inData == csum) ? DONE : ERROR;
`endif
                default: state_nx = IDLE;
            endcase
        end
    end

    // Index holds at the last address so it never wraps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            words_left <= '0;
            widx       <= '0;
        end else if (start) begin
            words_left <= '0;
            widx       <= '0;
        end else begin
            if (acc && state == COUNT) begin
                words_left <= n_words;
            end else if (data_en && last) begin
                words_left <= words_left - (ADDR_W+1)'(1);
            end
            if (memWe && words_left != '0) begin
                widx <= widx + ADDR_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_mips_imem_loader.sv
// Scoreboard bench for mips_imem_loader.
module tb_mips_imem_loader;

    localparam int ADDR_L = 64;
    localparam int ADDR_W = 6;

    typedef struct packed {
        logic [ADDR_W-1:0] a;
        logic [31:0]       d;
    } wr_t;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [7:0]        inData;
    logic              inValid;
    logic              inReady;
    logic              memWe;
    logic [ADDR_W-1:0] memAddr;
    logic [31:0]       memData;
    logic              holdPipe;
    logic              done;
    logic              error;

    int          checks = 0;
    int          errors = 0;
    int          nwrites = 0;
    int          nw0;
    logic [5:0]  last_addr = '0;
    logic        prev_we = 1'b0;
    logic [31:0] mem [0:ADDR_L-1];
    logic [31:0] fw [$];
    wr_t         exp_q [$];

    mips_imem_loader #(.ADDR_L(ADDR_L)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .inData   (inData),
        .inValid  (inValid),
        .inReady  (inReady),
        .memWe    (memWe),
        .memAddr  (memAddr),
        .memData  (memData),
        .holdPipe (holdPipe),
        .done     (done),
        .error    (error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard on every write strobe.
    initial begin
        wr_t e;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1) begin
                chk("inReady", inReady, !memWe);
                if (memWe) begin
                    chk("we_pulse", prev_we, 0);
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_write: addr %0d data %h",
                                 memAddr, memData);
                    end else begin
                        e = exp_q.pop_front();
                        chk("wr_addr", memAddr, e.a);
                        chk("wr_data", memData, e.d);
                    end
                    mem[memAddr] = memData;
                    nwrites++;
                    last_addr = memAddr;
                end
                prev_we = memWe;
            end else begin
                prev_we = 1'b0;
            end
        end
    end

    task automatic send(input logic [7:0] b, input bit jit);
        int t;
        if (jit) repeat ($urandom_range(0, 2)) @(negedge clk);
        @(negedge clk);
        inData  = b;
        inValid = 1'b1;
        t = 0;
        while (!inReady && t < 8) begin
            @(negedge clk);
            t++;
        end
        if (!inReady) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: byte %h not accepted", b);
        end
        @(posedge clk);
        #1;
        inValid = 1'b0;
    endtask

    task automatic frame(input logic [7:0] n, input bit bad, input bit jit);
        logic [7:0]  cs;
        logic [31:0] w;
        wr_t         e;
        cs = 8'd0;
        send(8'hA5, jit);
        send(n, jit);
        for (int i = 0; i < fw.size(); i++) begin
            w   = fw[i];
            e.a = ADDR_W'(i);
            e.d = w;
            exp_q.push_back(e);
            for (int k = 3; k >= 0; k--) begin
                send(w[8*k +: 8], jit);
                cs = cs + w[8*k +: 8];
            end
        end
`ifdef MIPS_IMEM_LOADER_CHECKSUM_EN
        send(bad ? cs + 8'd1 : cs, jit);
`else
        if (bad) $display("note: checksum disabled, bad flag ignored");
`endif
    endtask

    task automatic expect_done(input string tag);
`ifndef MIPS_IMEM_LOADER_CHECKSUM_EN
        chk({tag, "_hold_wr"}, holdPipe, 1);
        chk({tag, "_done_wr"}, done, 0);
        @(posedge clk);
        #1;
`endif
        chk({tag, "_hold"}, holdPipe, 0);
        chk({tag, "_done"}, done, 1);
        chk({tag, "_error"}, error, 0);
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_inReady"}, inReady, 1);
        chk({tag, "_memWe"}, memWe, 0);
        chk({tag, "_memAddr"}, memAddr, 0);
        chk({tag, "_memData"}, memData, 0);
        chk({tag, "_hold"}, holdPipe, 1);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_error"}, error, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n   = 1'b0;
        inValid = 1'b0;
        inData  = 8'h00;
        #12;
        check_reset("rst");
        @(negedge clk);
        rst_n = 1'b1;

        // Basic two-word frame; data checksum is 8'h39.
        fw = '{32'h00000001, 32'hDEADBEEF};
        frame(8'h02, 1'b0, 1'b0);
        expect_done("f1");
        chk("f1_m0", mem[0], 32'h00000001);
        chk("f1_m1", mem[1], 32'hDEADBEEF);

`ifdef MIPS_IMEM_LOADER_CHECKSUM_EN
        nw0 = nwrites;
        frame(8'h02, 1'b1, 1'b0);
        chk("bad_error", error, 1);
        chk("bad_hold", holdPipe, 1);
        chk("bad_done", done, 0);
        chk("bad_writes", nwrites - nw0, 2);
        frame(8'h02, 1'b0, 1'b0);
        expect_done("recover");
`endif

        // Count above depth is rejected before any write.
        nw0 = nwrites;
        send(8'hA5, 1'b0);
        send(8'h41, 1'b0);
        chk("ovf_error", error, 1);
        chk("ovf_hold", holdPipe, 1);
        chk("ovf_done", done, 0);
        repeat (3) @(negedge clk);
        chk("ovf_nowrite", nwrites - nw0, 0);

        // Count 0 means full depth.
        fw.delete();
        for (int i = 0; i < ADDR_L; i++) begin
            fw.push_back({8'(i), 8'(i) ^ 8'h5A, 8'(255 - i), 8'(i * 3)});
        end
        nw0 = nwrites;
        frame(8'h00, 1'b0, 1'b0);
        expect_done("full");
        chk("full_writes", nwrites - nw0, ADDR_L);
        chk("full_last", last_addr, 63);
        chk("full_m63", mem[63], {8'd63, 8'd63 ^ 8'h5A, 8'd192, 8'd189});
        repeat (2) @(negedge clk);
        chk("full_addr_hold", memAddr, 63);

        // Junk before header, ragged inValid.
        send(8'h3C, 1'b1);
        send(8'h11, 1'b1);
        chk("junk_done", done, 1);
        fw = '{32'h00000001, 32'hDEADBEEF};
        frame(8'h02, 1'b0, 1'b1);
        expect_done("jit");
        chk("jit_m0", mem[0], 32'h00000001);
        chk("jit_m1", mem[1], 32'hDEADBEEF);

        // Reset mid-frame after six data bytes.
        fw = '{32'h11223344};
        frame(8'h02, 1'b0, 1'b0);
        send(8'h55, 1'b0);
        send(8'h66, 1'b0);
        #3;
        rst_n = 1'b0;
        #1;
        check_reset("mid");
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        fw = '{32'hCAFEF00D, 32'h0BADC0DE};
        frame(8'h02, 1'b0, 1'b0);
        expect_done("fresh");
        chk("fresh_m0", mem[0], 32'hCAFEF00D);
        chk("fresh_m1", mem[1], 32'h0BADC0DE);

        repeat (3) @(negedge clk);
        chk("exp_q_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
